serial_async_rx_ovs: RTL and testbench

//  Oversampling asynchronous serial receiver; next generation of serial_async_rx.

---
 rtl/serial_async_rx_ovs.sv | 194 +++++++++++++++++++
 tb/tb_serial_async_rx_ovs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_async_rx_ovs.sv
// Oversampling async serial receiver with majority vote, false-start rejection,
// configurable parity and stop bits, and a FWFT receive FIFO with sticky overrun.
module serial_async_rx_ovs #(
   parameter int BITS          = 8,
   parameter int LOWBIT_FIRST  = 1,
   parameter int PARITY_MODE   = 1,
   parameter int STOP_BITS     = 1,
   parameter int MAIN_CLK_HZ   = 80_000,
   parameter int SERIAL_CLK_HZ = 10_000,
   parameter int OVERSAMPLE    = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          in_clk,
   input  logic                          in_rst,
   input  logic                          in_enable,
   input  logic                          in_serial,
   input  logic                          in_read,
   input  logic                          in_clear_err,
   output logic [BITS-1:0]               out_parallel,
   output logic                          out_parity_err,
   output logic                          out_frame_err,
   output logic                          out_valid,
   output logic [$clog2(FIFO_DEPTH):0]   out_fill,
   output logic                          out_overrun,
   output logic                          out_busy
);

   localparam int DIV     = MAIN_CLK_HZ / (SERIAL_CLK_HZ * OVERSAMPLE);
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int T_W     = $clog2(OVERSAMPLE);
   localparam int CNT_W   = $clog2(BITS + STOP_BITS + 1);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int FILL_W  = PTR_W + 1;
   localparam int ENTRY_W = BITS + 2;

   localparam logic [T_W-1:0]   T_S0   = T_W'(OVERSAMPLE / 2 - 1);
   localparam logic [T_W-1:0]   T_S1   = T_W'(OVERSAMPLE / 2);
   localparam logic [T_W-1:0]   T_S2   = T_W'(OVERSAMPLE / 2 + 1);
   localparam logic [T_W-1:0]   T_LAST = T_W'(OVERSAMPLE - 1);
   // The start-detect clock itself is the first divider phase of tick t=0.
   localparam logic [T_W-1:0]   T_FIRST   = (DIV == 1) ? T_W'(1) : '0;
   localparam logic [DIV_W-1:0] DIV_FIRST = (DIV == 1) ? '0 : DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

   if (DIV < 1) begin : g_div_check
      $error("serial_async_rx_ovs: MAIN_CLK_HZ too low for SERIAL_CLK_HZ*OVERSAMPLE");
   end

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   state_t               r_state;
   logic                 r_sync1, r_sync2;
   logic [DIV_W-1:0]     r_div;
   logic [T_W-1:0]       r_t;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_s0, r_s1;
   logic [BITS-1:0]      r_shift;
   logic                 r_perr, r_ferr;
   logic                 r_push;
   logic [ENTRY_W-1:0]   r_push_word;

   logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [FILL_W-1:0]    r_fill;
   logic                 r_overrun;

   logic                 w_rx, w_tick, w_maj, w_ferr_now;
   logic                 w_pop, w_full, w_wr;
   logic [ENTRY_W-1:0]   w_head;

   assign w_rx       = r_sync2;
   assign w_tick     = (r_div == DIV_LAST);
   assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
   assign w_ferr_now = r_ferr | ~w_maj;

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= in_serial;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_t         <= '0;
         r_cnt       <= '0;
         r_s0        <= 1'b1;
         r_s1        <= 1'b1;
         r_shift     <= '0;
         r_perr      <= 1'b0;
         r_ferr      <= 1'b0;
         r_push      <= 1'b0;
         r_push_word <= '0;
      end else begin
         // NOTE: default first so the push strobe lasts exactly one clock.
         r_push <= 1'b0;
         if (!in_enable) begin
            r_state <= ST_IDLE;
         end else if (r_state == ST_IDLE) begin
            if (!w_rx) begin
               r_state <= ST_START;
               r_t     <= T_FIRST;
               r_div   <= DIV_FIRST;
            end
         end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
               r_t <= (r_t == T_LAST) ? '0 : r_t + T_W'(1);
               if (r_t == T_S0) r_s0 <= w_rx;
               if (r_t == T_S1) r_s1 <= w_rx;
               if (r_t == T_S2) begin
                  case (r_state)
                     ST_START: begin
                        r_state <= w_maj ? ST_IDLE : ST_DATA;
                        r_cnt   <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                     end
                     ST_DATA: begin
                        if (LOWBIT_FIRST != 0) r_shift <= {w_maj, r_shift[BITS-1:1]};
                        else                   r_shift <= {r_shift[BITS-2:0], w_maj};
                        if (r_cnt == CNT_W'(BITS - 1)) begin
                           r_cnt   <= '0;
                           r_state <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                           r_cnt <= r_cnt + CNT_W'(1);
                        end
                     end
                     ST_PARITY: begin
                        r_perr  <= ((w_maj ^ (^r_shift)) != (PARITY_MODE == 2));
                        r_state <= ST_STOP;
                     end
                     ST_STOP: begin
                        if (r_cnt == CNT_W'(STOP_BITS - 1)) begin
                           // Leave mid-way through the last stop bit so the next start edge is never missed.
                           r_push      <= 1'b1;
                           r_push_word <= {r_perr, w_ferr_now, r_shift};
                           r_state     <= ST_IDLE;
                        end else begin
                           r_ferr <= w_ferr_now;
                           r_cnt  <= r_cnt + CNT_W'(1);
                        end
                     end
                     default: r_state <= ST_IDLE;
                  endcase
               end
            end
         end
      end
   end

   assign w_pop  = in_read && (r_fill != '0);
   assign w_full = (r_fill == FILL_W'(FIFO_DEPTH));
   assign w_wr   = r_push && (!w_full || w_pop);

   // NOTE: storage has no reset; emptiness is tracked by r_fill and outputs are gated by it.
   always_ff @(posedge in_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_push_word;
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_fill    <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr, w_pop})
            2'b10:   r_fill <= r_fill + FILL_W'(1);
            2'b01:   r_fill <= r_fill - FILL_W'(1);
            default: r_fill <= r_fill;
         endcase
         if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
         else if (in_clear_err)          r_overrun <= 1'b0;
      end
   end

   assign w_head         = r_mem[r_rd_ptr];
   assign out_valid      = (r_fill != '0);
   assign out_fill       = r_fill;
   assign out_parallel   = out_valid ? w_head[BITS-1:0] : '0;
   assign out_frame_err  = out_valid & w_head[BITS];
   assign out_parity_err = out_valid & w_head[BITS+1];
   assign out_overrun    = r_overrun;
   assign out_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_async_rx_ovs.sv
// Bench for serial_async_rx_ovs: instance A uses default parameters (LSB first, even parity,
// 1 stop); instance B uses odd parity, 2 stops, MSB first and is fed with a fast transmitter.
`timescale 1ns/1ps
module tb_serial_async_rx_ovs;

   localparam real BIT_NS = 80.0;

   logic       in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   logic       rst_a, en_a, ser_a, rd_a, clr_a;
   logic [7:0] par_a;
   logic       perr_a, ferr_a, valid_a, ovr_a, busy_a;
   logic [2:0] fill_a;

   logic       rst_b, en_b, ser_b, rd_b, clr_b;
   logic [7:0] par_b;
   logic       perr_b, ferr_b, valid_b, ovr_b, busy_b;
   logic [2:0] fill_b;

   serial_async_rx_ovs u_dut_a (
      .in_clk(in_clk), .in_rst(rst_a), .in_enable(en_a), .in_serial(ser_a),
      .in_read(rd_a), .in_clear_err(clr_a), .out_parallel(par_a),
      .out_parity_err(perr_a), .out_frame_err(ferr_a), .out_valid(valid_a),
      .out_fill(fill_a), .out_overrun(ovr_a), .out_busy(busy_a));

   serial_async_rx_ovs #(.LOWBIT_FIRST(0), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_b (
      .in_clk(in_clk), .in_rst(rst_b), .in_enable(en_b), .in_serial(ser_b),
      .in_read(rd_b), .in_clear_err(clr_b), .out_parallel(par_b),
      .out_parity_err(perr_b), .out_frame_err(ferr_b), .out_valid(valid_b),
      .out_fill(fill_b), .out_overrun(ovr_b), .out_busy(busy_b));

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         bad_stop;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input int which, input logic v);
      if (which == 0) ser_a = v;
      else            ser_b = v;
   endtask

   // Reference transmitter: frame built from the line-format rules of each instance.
   task automatic send(input int which, input logic [7:0] data, input real bit_ns,
                       input bit bad_par, input bit bad_stop);
      logic fr[$];
      bit   lsb_first = (which == 0);
      bit   odd       = (which != 0);
      int   n_stop    = (which == 0) ? 1 : 2;
      logic par_bit;
      fr.push_back(1'b0);
      for (int i = 0; i < 8; i++) fr.push_back(lsb_first ? data[i] : data[7-i]);
      par_bit = (^data) ^ odd;
      fr.push_back(par_bit ^ bad_par);
      for (int i = 0; i < n_stop; i++) fr.push_back(!(bad_stop && i == n_stop - 1));
      foreach (fr[i]) begin
         drive(which, fr[i]);
         #(bit_ns);
      end
      drive(which, 1'b1);
      #(2.0 * bit_ns);
   endtask

   task automatic pop(input int which);
      @(negedge in_clk);
      if (which == 0) rd_a = 1'b1;
      else            rd_b = 1'b1;
      @(negedge in_clk);
      rd_a = 1'b0;
      rd_b = 1'b0;
   endtask

   initial begin
      #800us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      bit         seen_busy;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
      vecs[3] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1};

      rst_a = 1'b0; en_a = 1'b1; ser_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
      rst_b = 1'b0; en_b = 1'b1; ser_b = 1'b1; rd_b = 1'b0; clr_b = 1'b0;
      repeat (3) @(negedge in_clk);
      check("reset valid",   valid_a, 0);
      check("reset fill",    fill_a,  0);
      check("reset data",    par_a,   0);
      check("reset perr",    perr_a,  0);
      check("reset ferr",    ferr_a,  0);
      check("reset overrun", ovr_a,   0);
      check("reset busy",    busy_a,  0);
      check("reset B fill",  fill_b,  0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge in_clk);

      // Table-driven frames on A, including parity and framing errors.
      for (int i = 0; i < 7; i++) begin
         @(negedge in_clk);
         send(0, vecs[i].data, BIT_NS, vecs[i].bad_par, vecs[i].bad_stop);
         @(negedge in_clk);
         check($sformatf("vec%0d valid", i), valid_a, 1);
         check($sformatf("vec%0d fill", i),  fill_a,  1);
         check($sformatf("vec%0d data", i),  par_a,   vecs[i].exp_data);
         check($sformatf("vec%0d perr", i),  perr_a,  vecs[i].exp_perr);
         check($sformatf("vec%0d ferr", i),  ferr_a,  vecs[i].exp_ferr);
         check($sformatf("vec%0d busy", i),  busy_a,  0);
         pop(0);
         check($sformatf("vec%0d popped", i), fill_a, 0);
      end

      // Short low glitch on idle line is a false start.
      @(negedge in_clk);
      ser_a = 1'b0;
      repeat (2) @(negedge in_clk);
      ser_a = 1'b1;
      seen_busy = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge in_clk);
         if (busy_a) seen_busy = 1'b1;
      end
      check("glitch busy seen",     seen_busy, 1);
      check("glitch busy released", busy_a,    0);
      check("glitch fill",          fill_a,    0);

      // Disabling mid-frame discards the partial frame.
      @(negedge in_clk);
      fork
         send(0, 8'hC3, BIT_NS, 1'b0, 1'b0);
         begin
            #(4.0 * BIT_NS);
            en_a = 1'b0;
            repeat (2) @(negedge in_clk);
            check("disable busy", busy_a, 0);
         end
      join
      @(negedge in_clk);
      check("disable fill", fill_a, 0);
      en_a = 1'b1;
      @(negedge in_clk);
      send(0, 8'h5A, BIT_NS, 1'b0, 1'b0);
      @(negedge in_clk);
      check("reenable data", par_a, 8'h5A);
      pop(0);

      // Overrun: five words into a four-deep FIFO with no reads.
      for (int k = 1; k <= 5; k++) begin
         @(negedge in_clk);
         send(0, 8'(k), BIT_NS, 1'b0, 1'b0);
      end
      @(negedge in_clk);
      check("ovr fill",    fill_a, 4);
      check("ovr flag",    ovr_a,  1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovr read%0d", k), par_a, 8'(k));
         pop(0);
      end
      check("ovr drained",  fill_a, 0);
      check("ovr sticky",   ovr_a,  1);
      clr_a = 1'b1;
      @(negedge in_clk);
      clr_a = 1'b0;
      @(negedge in_clk);
      check("ovr cleared",  ovr_a,  0);
      pop(0);
      check("empty pop fill",  fill_a,  0);
      check("empty pop valid", valid_a, 0);

      // Random bytes into B from a 3% fast transmitter, with one mid-frame reset.
      for (int i = 0; i < 256; i++) begin
         if (i == 128) begin
            @(negedge in_clk);
            fork
               send(1, 8'($urandom_range(0, 255)), BIT_NS / 1.03, 1'b0, 1'b0);
               begin
                  #(5.0 * BIT_NS);
                  rst_b = 1'b0;
               end
            join
            @(negedge in_clk);
            check("midrst fill",  fill_b,  0);
            check("midrst valid", valid_b, 0);
            check("midrst busy",  busy_b,  0);
            rst_b = 1'b1;
            repeat (2) @(negedge in_clk);
         end
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         @(negedge in_clk);
         send(1, b, BIT_NS / 1.03, 1'b0, 1'b0);
         @(negedge in_clk);
         check($sformatf("rnd%0d valid", i), valid_b, 1);
         check($sformatf("rnd%0d data", i),  par_b,   exp_q.pop_front());
         check($sformatf("rnd%0d perr", i),  perr_b,  0);
         check($sformatf("rnd%0d ferr", i),  ferr_b,  0);
         pop(1);
      end
      check("rnd final fill", fill_b, 0);
      check("rnd overrun",    ovr_b,  0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
